mvm_stream_driver: RTL and testbench
====================================

Name: mvm_stream_driver

Overview:
- Host-side sequencer that drives a 4x4 matrix-vector multiplier's serial interface (start/data_in in, done/data_out back).
- Host preloads A (row-major, 16 elements) and x (4 elements) through a write port, then pulses go.
- Block issues start, streams the 20 operands cycle-exact, waits for done, and captures the 4 results into a readable result buffer.
- Sits between a host/testbench register interface and the multiplier core.

Parameters:
- MAT_SCALE, 4, matrix dimension; operand count N_OPS = MAT_SCALE*MAT_SCALE + MAT_SCALE.
- INPUT_WIDTH, 8, signed operand width.
- OUTPUT_WIDTH, 16, signed result width.
- CAPTURE_DELAY, 1, cycles from the cycle done=1 to the cycle y[0] is on mvm_data_out.
- TIMEOUT, 255, maximum cycles waited for done after the last operand is driven.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-low (reset==0 resets).
- ld_en  in  1  operand write strobe.
- ld_addr  in  5  0..15 = A[row*4+col], 16..19 = x[0..3]; addresses 20..31 ignored.
- ld_data  in  INPUT_WIDTH  signed operand.
- go  in  1  launch request.
- rd_addr  in  2  result index.
- rd_data  out  OUTPUT_WIDTH  y[rd_addr], combinational read of the result buffer.
- busy  out  1  high from accepted go until COMPLETE/ERROR exit.
- result_valid  out  1  set on successful capture; cleared by next accepted go or reset.
- err_timeout  out  1  set when done is not seen within TIMEOUT; cleared by next accepted go or reset.
- mvm_start  out  1  start to the multiplier.
- mvm_data_in  out  INPUT_WIDTH  operand stream to the multiplier.
- mvm_done  in  1  done from the multiplier.
- mvm_data_out  in  OUTPUT_WIDTH  result stream from the multiplier.

Behaviour:
- Reset (reset==0 at posedge):
  - State=IDLE; busy, result_valid, err_timeout, mvm_start = 0; mvm_data_in = 0; counters = 0.
  - Operand and result buffers are not cleared.
  - Reset mid-operation aborts immediately; mvm_start and mvm_data_in are 0 from the next cycle.
- Loads: ld_en is honoured only when busy==0; writes while busy are dropped.
- go:
  - Accepted only in IDLE, COMPLETE or ERROR (busy==0).
  - go while busy is ignored.
  - go and ld_en in the same cycle: the load lands first, and the new value is streamed.
- FSM states: IDLE, START, STREAM, WAIT_DONE, CAPTURE, ERROR; COMPLETE is IDLE with result_valid=1.
- IDLE --go--> START:
  - Registered mvm_start=1 for exactly one cycle (cycle S).
  - busy=1; result_valid and err_timeout cleared.
- START -> STREAM:
  - Cycles S+1 .. S+20 drive mvm_data_in = A[0]..A[15], then x[0]..x[3], one per cycle.
  - Operand counter 0..19; mvm_start=0 throughout.
- STREAM -> WAIT_DONE after operand 19.
  - mvm_data_in returns to 0.
  - Timeout counter starts at 0 and increments each cycle.
- WAIT_DONE:
  - On mvm_done==1 at cycle D, go to CAPTURE.
  - If the counter reaches TIMEOUT without done, go to ERROR: err_timeout=1, busy=0.
- CAPTURE:
  - Samples mvm_data_out at cycles D+CAPTURE_DELAY+k into y[k], k=0..3.
  - After y[3]: result_valid=1, busy=0, back to IDLE.
- Stray mvm_done:
  - Ignored in IDLE, START, STREAM, CAPTURE and ERROR.
  - A second done during CAPTURE does not restart the capture.
- Arithmetic: none. Results are stored bit-exact as received; any wrap in the multiplier is preserved.
- rd_data: combinational on rd_addr. Reading during capture returns old or new entries; host must wait for result_valid.
- Total latency go-accept to first operand: 2 cycles (start at S, A[0] at S+1).

Test Plan:
- A = identity, x = [1,2,3,4], go -> mvm_start high 1 cycle; mvm_data_in sequence 1,0,0,0,0,1,...,1,2,3,4 on consecutive cycles; result_valid=1; rd_data y = [1,2,3,4].
- A all 127, x all -128 -> y[k] = 512 for each k (4*127*-128 = -65024 wraps to 16 bits); err_timeout=0.
- A row r = [r+1, 0, 0, 0], x = [-3,5,7,9] -> y = [-3,-6,-9,-12]; a second go re-runs and yields identical results with no reload.
- Multiplier model never raises done -> err_timeout=1 exactly TIMEOUT cycles after the last operand; busy=0; result_valid=0; next go clears err_timeout and restarts.
- Pulse go and ld_en (addr 5, data 9) during STREAM -> both ignored; stream and buffer unchanged; after completion, addr 5 still holds its old value.
- Drive reset=0 at operand 10 -> next cycle busy=0, mvm_start=0, mvm_data_in=0; after release, a fresh go runs a full correct transaction.

Source files
------------

// File: rtl/mvm_stream_driver.sv
// Host-side sequencer for a 4x4 matrix-vector multiplier: holds operands written by the host,
// streams them to the core after a start pulse, then captures the four results for readback.
module mvm_stream_driver #(
    parameter int MAT_SCALE     = 4,
    parameter int INPUT_WIDTH   = 8,
    parameter int OUTPUT_WIDTH  = 16,
    parameter int CAPTURE_DELAY = 1,
    parameter int TIMEOUT       = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ld_en,
    input  logic [4:0]              ld_addr,
    input  logic [INPUT_WIDTH-1:0]  ld_data,
    input  logic                    go,
    input  logic [1:0]              rd_addr,
    output logic [OUTPUT_WIDTH-1:0] rd_data,
    output logic                    busy,
    output logic                    result_valid,
    output logic                    err_timeout,
    output logic                    mvm_start,
    output logic [INPUT_WIDTH-1:0]  mvm_data_in,
    input  logic                    mvm_done,
    input  logic [OUTPUT_WIDTH-1:0] mvm_data_out
);

    localparam int N_OPS = MAT_SCALE * MAT_SCALE + MAT_SCALE;
    localparam int OP_W  = $clog2(N_OPS);
    localparam int RES_W = $clog2(MAT_SCALE);
    localparam int CNT_W = $clog2(TIMEOUT + CAPTURE_DELAY + MAT_SCALE + 1);

    localparam logic [OP_W-1:0]  OP_LAST  = OP_W'(N_OPS - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 2);
    localparam logic [CNT_W-1:0] CAP_DLY  = CNT_W'(CAPTURE_DELAY);
    localparam logic [RES_W-1:0] RES_LAST = RES_W'(MAT_SCALE - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_STREAM    = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_CAPTURE   = 3'd4,
        S_ERROR     = 3'd5
    } state_t;

    state_t                  r_state;
    logic                    r_busy;
    logic                    r_valid;
    logic                    r_err;
    logic                    r_start;
    logic [INPUT_WIDTH-1:0]  r_data;
    logic [OP_W-1:0]         r_op_idx;
    logic [CNT_W-1:0]        r_cnt;
    logic [INPUT_WIDTH-1:0]  r_ops [0:N_OPS-1];
    logic [OUTPUT_WIDTH-1:0] r_y   [0:MAT_SCALE-1];

    state_t                  w_state_nxt;
    logic                    w_busy_nxt;
    logic                    w_valid_nxt;
    logic                    w_err_nxt;
    logic                    w_start_nxt;
    logic [INPUT_WIDTH-1:0]  w_data_nxt;
    logic [OP_W-1:0]         w_op_idx_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [OP_W-1:0]         w_op_inc;
    logic                    w_cap_en;
    logic [RES_W-1:0]        w_cap_idx;
    logic                    w_ld_ok;

    assign w_op_inc = r_op_idx + OP_W'(1);
    assign w_ld_ok  = ld_en && !r_busy && (ld_addr < 5'(N_OPS));

    // Next-state and next-output decode for the sequencer.
    always_comb begin
        w_state_nxt  = r_state;
        w_busy_nxt   = r_busy;
        w_valid_nxt  = r_valid;
        w_err_nxt    = r_err;
        w_start_nxt  = 1'b0;
        w_data_nxt   = {INPUT_WIDTH{1'b0}};
        w_op_idx_nxt = r_op_idx;
        w_cnt_nxt    = r_cnt;
        w_cap_en     = 1'b0;
        w_cap_idx    = RES_W'(r_cnt - CAP_DLY);
        case (r_state)
            S_IDLE, S_ERROR: begin
                if (go) begin
                    w_state_nxt  = S_START;
                    w_start_nxt  = 1'b1;
                    w_busy_nxt   = 1'b1;
                    w_valid_nxt  = 1'b0;
                    w_err_nxt    = 1'b0;
                    w_op_idx_nxt = {OP_W{1'b0}};
                    w_cnt_nxt    = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt  = r_state;
                end
            end
            S_START: begin
                w_state_nxt  = S_STREAM;
                w_data_nxt   = r_ops[0];
                w_op_idx_nxt = {OP_W{1'b0}};
            end
            S_STREAM: begin
                if (r_op_idx == OP_LAST) begin
                    w_state_nxt = S_WAIT_DONE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_op_idx_nxt = w_op_inc;
                    w_data_nxt   = r_ops[w_op_inc];
                end
            end
            S_WAIT_DONE: begin
                // Leaving at TIMEOUT-2 makes err_timeout rise exactly TIMEOUT cycles after the last operand.
                if (mvm_done) begin
                    w_state_nxt = S_CAPTURE;
                    w_cnt_nxt   = CNT_W'(1);
                end else if (r_cnt == TMO_LAST) begin
                    w_state_nxt = S_ERROR;
                    w_err_nxt   = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt >= CAP_DLY) begin
                    w_cap_en = 1'b1;
                    if (w_cap_idx == RES_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_valid_nxt = 1'b1;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_CAPTURE;
                    end
                end else begin
                    w_cap_en = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_start  <= 1'b0;
            r_data   <= {INPUT_WIDTH{1'b0}};
            r_op_idx <= {OP_W{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
        end else begin
            r_state  <= w_state_nxt;
            r_busy   <= w_busy_nxt;
            r_valid  <= w_valid_nxt;
            r_err    <= w_err_nxt;
            r_start  <= w_start_nxt;
            r_data   <= w_data_nxt;
            r_op_idx <= w_op_idx_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Operand buffer; survives reset so the host need not reload after an abort.
    always_ff @(posedge clk) begin
        if (w_ld_ok) begin
            r_ops[ld_addr] <= ld_data;
        end
    end

    // Result buffer, written bit-exact from the core's output stream.
    always_ff @(posedge clk) begin
        if (reset && w_cap_en) begin
            r_y[w_cap_idx] <= mvm_data_out;
        end
    end

    assign rd_data      = r_y[rd_addr];
    assign busy         = r_busy;
    assign result_valid = r_valid;
    assign err_timeout  = r_err;
    assign mvm_start    = r_start;
    assign mvm_data_in  = r_data;

endmodule

// File: tb/tb_mvm_stream_driver.sv
// Directed bench for mvm_stream_driver with a behavioural 4x4 multiplier core on the far side.
module tb_mvm_stream_driver;

    logic        clk;
    logic        reset;
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        go;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;
    logic        busy;
    logic        result_valid;
    logic        err_timeout;
    logic        mvm_start;
    logic [7:0]  mvm_data_in;
    logic        mvm_done;
    logic [15:0] mvm_data_out;

    int n_tests = 0;
    int n_fail  = 0;
    int ops_q [20];
    int m_latency    = 3;
    bit m_done_en    = 1'b1;
    bit m_extra_done = 1'b0;

    mvm_stream_driver dut (
        .clk          (clk),
        .reset        (reset),
        .ld_en        (ld_en),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .go           (go),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy),
        .result_valid (result_valid),
        .err_timeout  (err_timeout),
        .mvm_start    (mvm_start),
        .mvm_data_in  (mvm_data_in),
        .mvm_done     (mvm_done),
        .mvm_data_out (mvm_data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Multiplier core model: collects 20 operands after start, raises done, streams y[0..3].
    initial begin
        int cnt;
        int wcnt;
        int k;
        int acc;
        int m_ops [20];
        int phase;
        logic [15:0] y16 [4];
        mvm_done = 1'b0;
        mvm_data_out = 16'h5A5A;
        phase = 0; cnt = 0; wcnt = 0; k = 0;
        forever begin
            @(posedge clk); #1;
            mvm_done = 1'b0;
            mvm_data_out = 16'h5A5A;
            if (mvm_start) begin
                phase = 1;
                cnt = 0;
            end else begin
                case (phase)
                    1: begin
                        m_ops[cnt] = $signed(mvm_data_in);
                        cnt++;
                        if (cnt == 20) begin
                            phase = 2;
                            wcnt = m_latency;
                            for (int r = 0; r < 4; r++) begin
                                acc = 0;
                                for (int c = 0; c < 4; c++) acc += m_ops[r*4+c] * m_ops[16+c];
                                y16[r] = acc[15:0];
                            end
                        end
                    end
                    2: begin
                        if (m_done_en) begin
                            if (wcnt <= 1) begin
                                mvm_done = 1'b1;
                                phase = 3;
                                k = 0;
                            end else begin
                                wcnt--;
                            end
                        end
                    end
                    3: begin
                        mvm_data_out = y16[k];
                        mvm_done = m_extra_done && (k == 1);
                        k++;
                        if (k == 4) phase = 0;
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_ops(input int upto);
        for (int i = 0; i < upto; i++) begin
            ld_en = 1'b1; ld_addr = 5'(i); ld_data = 8'(ops_q[i]);
            tick();
        end
        ld_en = 1'b0;
    endtask

    // Pulses go, checks the start cycle and every streamed operand cycle by cycle.
    task automatic launch(input string tag, input bit ld_with_go, input bit disturb);
        go = 1'b1;
        if (ld_with_go) begin
            ld_en = 1'b1; ld_addr = 5'd19; ld_data = 8'(ops_q[19]);
        end
        tick();
        go = 1'b0; ld_en = 1'b0;
        check_eq({tag, "_start"}, int'(mvm_start), 1);
        check_eq({tag, "_busy"}, int'(busy), 1);
        check_eq({tag, "_valid_clr"}, int'(result_valid), 0);
        check_eq({tag, "_err_clr"}, int'(err_timeout), 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (disturb && i == 3) begin
                go = 1'b0; ld_en = 1'b0;
            end
            if (i == 0) check_eq({tag, "_start_low"}, int'(mvm_start), 0);
            check_eq($sformatf("%s_op%0d", tag, i), $signed(mvm_data_in), ops_q[i]);
            if (disturb && i == 2) begin
                go = 1'b1; ld_en = 1'b1; ld_addr = 5'd5; ld_data = 8'd9;
            end
        end
        tick();
        check_eq({tag, "_data_idle"}, $signed(mvm_data_in), 0);
        check_eq({tag, "_busy_wait"}, int'(busy), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        check_eq({tag, "_idle"}, int'(busy), 0);
    endtask

    task automatic check_y(input string tag, input int e0, input int e1, input int e2, input int e3);
        int exp_y [4];
        exp_y[0] = e0; exp_y[1] = e1; exp_y[2] = e2; exp_y[3] = e3;
        check_eq({tag, "_valid"}, int'(result_valid), 1);
        check_eq({tag, "_err"}, int'(err_timeout), 0);
        for (int k = 0; k < 4; k++) begin
            rd_addr = 2'(k);
            #1;
            check_eq($sformatf("%s_y%0d", tag, k), $signed(rd_data), exp_y[k]);
        end
    endtask

    initial begin
        int n;
        reset = 1'b0; ld_en = 1'b0; ld_addr = 5'd0; ld_data = 8'd0; go = 1'b0; rd_addr = 2'd0;
        repeat (3) tick();
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_valid", int'(result_valid), 0);
        check_eq("rst_err", int'(err_timeout), 0);
        check_eq("rst_start", int'(mvm_start), 0);
        check_eq("rst_data", int'(mvm_data_in), 0);
        reset = 1'b1;
        tick();

        // Identity matrix, x = 1..4.
        for (int i = 0; i < 16; i++) ops_q[i] = (i % 5 == 0) ? 1 : 0;
        for (int i = 0; i < 4; i++) ops_q[16+i] = i + 1;
        load_ops(20);
        launch("ident", 1'b0, 1'b0);
        wait_idle("ident");
        check_y("ident", 1, 2, 3, 4);

        // All 127 times all -128 wraps to 512; x[3] is written in the go cycle.
        for (int i = 0; i < 16; i++) ops_q[i] = 127;
        for (int i = 16; i < 20; i++) ops_q[i] = -128;
        load_ops(19);
        launch("wrap", 1'b1, 1'b0);
        wait_idle("wrap");
        check_y("wrap", 512, 512, 512, 512);

        // Column matrix; a repeated done in capture must not restart it; rerun with no reload.
        for (int i = 0; i < 16; i++) ops_q[i] = (i % 4 == 0) ? (i / 4 + 1) : 0;
        ops_q[16] = -3; ops_q[17] = 5; ops_q[18] = 7; ops_q[19] = 9;
        load_ops(20);
        m_extra_done = 1'b1;
        launch("col", 1'b0, 1'b0);
        wait_idle("col");
        m_extra_done = 1'b0;
        check_y("col", -3, -6, -9, -12);
        launch("col_rerun", 1'b0, 1'b0);
        wait_idle("col_rerun");
        check_y("col_rerun", -3, -6, -9, -12);

        // Core never answers: error exactly TIMEOUT cycles after the last operand.
        m_done_en = 1'b0;
        go = 1'b1; tick(); go = 1'b0;
        repeat (20) tick();
        n = 0;
        while (!err_timeout && n < 400) begin
            tick();
            n++;
        end
        check_eq("tmo_cycles", n, 255);
        check_eq("tmo_err", int'(err_timeout), 1);
        check_eq("tmo_busy", int'(busy), 0);
        check_eq("tmo_valid", int'(result_valid), 0);
        m_done_en = 1'b1;
        launch("tmo_restart", 1'b0, 1'b0);
        wait_idle("tmo_restart");
        check_y("tmo_restart", -3, -6, -9, -12);

        // go and a load to addr 5 while streaming are both dropped.
        launch("busy_ign", 1'b0, 1'b1);
        wait_idle("busy_ign");
        check_y("busy_ign", -3, -6, -9, -12);
        launch("addr5_kept", 1'b0, 1'b0);
        wait_idle("addr5_kept");
        check_y("addr5_kept", -3, -6, -9, -12);

        // Reset while operand 10 is on the bus.
        go = 1'b1; tick(); go = 1'b0;
        repeat (11) tick();
        check_eq("rstmid_op10", $signed(mvm_data_in), ops_q[10]);
        reset = 1'b0;
        tick();
        check_eq("rstmid_busy", int'(busy), 0);
        check_eq("rstmid_start", int'(mvm_start), 0);
        check_eq("rstmid_data", int'(mvm_data_in), 0);
        reset = 1'b1;
        repeat (30) tick();
        check_eq("rstmid_stray_valid", int'(result_valid), 0);
        check_eq("rstmid_stray_busy", int'(busy), 0);
        launch("rst_fresh", 1'b0, 1'b0);
        wait_idle("rst_fresh");
        check_y("rst_fresh", -3, -6, -9, -12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
